// File: rtl/rom_access_arbiter_pkg.sv
// Shared types and constants for the two-requester user-ROM arbiter.
package rom_access_arbiter_pkg;

    typedef enum logic [1:0] {
        sIdle = 2'd0,
        sAddr = 2'd1,
        sCap  = 2'd2
    } state_t;

    localparam logic REQ_LOGIN = 1'b0;
    localparam logic REQ_SCORE = 1'b1;

    // End-of-memory marker stored in the ROM; passed through untouched here.
    localparam logic [15:0] ROM_EOM = 16'hFFFF;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rom_access_arbiter_if.sv
// Requester and ROM-side signals of the arbiter; slave is the arbiter's view.
interface rom_access_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic [1:0]        req;
    logic [1:0]        lock;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [1:0]        gnt;
    logic [DATA_W-1:0] rd_data;
    logic [1:0]        rd_valid;
    logic              busy;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;

    modport master (
        output req, lock, addr0, addr1, rom_data,
        input  gnt, rd_data, rd_valid, busy, rom_addr
    );

    modport slave (
        input  req, lock, addr0, addr1, rom_data,
        output gnt, rd_data, rd_valid, busy, rom_addr
    );
endinterface

// File: rtl/rom_access_arbiter_pick.sv
// Two-way round-robin pick with lock ownership and hold-limit override.
// Latency: purely combinational.
// Backpressure: none; the caller only samples the result while idle.
module rr_pick2
    import rom_access_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       own_vld,
    input  logic       own,
    input  logic       hold_lim,
    output logic [1:0] gnt
);
    logic other;
    assign other = ~own;

    always_comb begin
        gnt = 2'b00;
        if (own_vld && req[own]) begin
            // Owner keeps the ROM unless it has used up its hold budget while
            // the other side is waiting.
            gnt = (hold_lim && req[other]) ? onehot2(other) : onehot2(own);
        end else begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = onehot2(~last);
                default: gnt = 2'b00;
            endcase
        end
    end
endmodule

// File: rtl/rom_access_arbiter.sv
// Shares one synchronous ROM between the login scanner and the score lookup.
// Latency: grant in the request cycle, rd_valid three cycles later; one read per 3 cycles.
// Backpressure: req is level and held until gnt; no overlap, losers simply wait.
module rom_access_arbiter
    import rom_access_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 16,
    parameter int MAX_HOLD = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    rom_access_arbiter_if.slave  bus
);
    localparam int              HW       = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0]   HOLD_MAX = HW'(MAX_HOLD);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [1:0]        rd_valid_q, rd_valid_d;
    logic              last_q, last_d;
    logic              own_vld_q, own_vld_d;
    logic              owner_q, owner_d;
    logic [HW-1:0]     hold_cnt, hold_d;

    logic [1:0]        pick;
    logic              idle;
    logic              gidx;

    assign idle = (state_q == sIdle);
    assign gidx = pick[1];

    rr_pick2 u_pick (
        .req      (bus.req),
        .last     (last_q),
        .own_vld  (own_vld_q),
        .own      (owner_q),
        .hold_lim (hold_cnt == HOLD_MAX),
        .gnt      (pick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= sIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rom_addr_d = rom_addr_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 2'b00;
        last_d     = last_q;
        own_vld_d  = own_vld_q;
        owner_d    = owner_q;
        hold_d     = hold_cnt;

        case (state_q)
            sIdle: begin
                // A locked owner that stopped requesting gives up its lock now.
                if (own_vld_q && !bus.req[owner_q]) begin
                    own_vld_d = 1'b0;
                    hold_d    = '0;
                end
                if (pick != 2'b00) begin
                    state_d    = sAddr;
                    rom_addr_d = gidx ? bus.addr1 : bus.addr0;
                    last_d     = gidx;
                    if (own_vld_q && owner_q == gidx) begin
                        hold_d = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + HW'(1);
                    end else begin
                        hold_d = HW'(1);
                    end
                    own_vld_d = 1'b1;
                    owner_d   = gidx;
                end
            end
            sAddr: begin
                state_d = sCap;
            end
            sCap: begin
                rd_data_d  = bus.rom_data;
                rd_valid_d = onehot2(owner_q);
                if (!bus.lock[owner_q]) begin
                    own_vld_d = 1'b0;
                    hold_d    = '0;
                end
                state_d = sIdle;
            end
            default: begin
                state_d   = sIdle;
                own_vld_d = 1'b0;
                hold_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rom_addr_q <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 2'b00;
            last_q     <= REQ_SCORE;
            own_vld_q  <= 1'b0;
            owner_q    <= REQ_LOGIN;
            hold_cnt   <= '0;
        end else begin
            rom_addr_q <= rom_addr_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            last_q     <= last_d;
            own_vld_q  <= own_vld_d;
            owner_q    <= owner_d;
            hold_cnt   <= hold_d;
        end
    end

    // Grant is a Mealy output of sIdle; masked so reset forces it low at once.
    assign bus.gnt      = (idle && rst) ? pick : 2'b00;
    assign bus.rom_addr = rom_addr_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.busy     = ~idle;

endmodule

// File: doc/rom_access_arbiter.md
# rom_access_arbiter

Shares the single synchronous user ROM between two requesters: the login password scanner (requester 0) and the high-score/level lookup (requester 1). It sequences each read through the ROM's one-cycle address-register latency and returns data to the owning requester with a per-requester valid pulse. Round-robin arbitration applies, and a bounded lock lets the scanner walk consecutive addresses without losing the ROM to the other requester.

## Interface
- ADDR_W, 8, ROM address width
- DATA_W, 16, ROM word width
- MAX_HOLD, 16, max consecutive locked grants to one owner while the other requester waits (≥1)

- clk  in  1  system clock, all state on posedge
- rst  in  1  asynchronous, active-low reset
- req  in  2  per-requester read request, level, held until gnt
- lock  in  2  per-requester: keep ownership after the current access
- addr0  in  ADDR_W  requester 0 address, stable while req[0] high
- addr1  in  ADDR_W  requester 1 address, stable while req[1] high
- gnt  out  2  one-cycle grant pulse, one-hot or zero
- rd_data  out  DATA_W  shared read-data bus, held until next capture
- rd_valid  out  2  one-cycle pulse, rd_data valid for that requester
- busy  out  1  high while an access is in flight (state ≠ sIdle)
- rom_addr  out  ADDR_W  registered address to the ROM
- rom_data  in  DATA_W  ROM output, valid one cycle after the ROM samples rom_addr

## Operation
- Reset values: gnt=0, rd_valid=0, rd_data=0, rom_addr=0, busy=0, state=sIdle, owner=none, last=1 (requester 0 wins the first tie), hold_cnt=0.
- States:
  - sIdle: evaluate req → sAddr on a grant, else stay.
  - sAddr: ROM samples rom_addr → sCap.
  - sCap: rd_data<=rom_data, rd_valid[owner]<=1 → sIdle.
- Arbitration in sIdle, highest rule first:
  - Locked owner present and req[owner] high: owner wins, unless hold_cnt==MAX_HOLD and the other requester is requesting. In that case the other requester wins and the lock is dropped.
  - No locked owner: single requester wins. If both request, the one ≠ last wins.
- On grant to i:
  - gnt[i]=1 for one cycle.
  - rom_addr<=addr_i, last<=i.
  - hold_cnt increments if i was the locked owner, else resets to 1.
- Lock retention: at sCap, owner is retained iff lock[owner]=1. Otherwise owner=none and hold_cnt=0.
- Locked owner that drops req in sIdle: lock is released in that cycle, and the other requester may be granted in the same cycle.
- req seen high in sIdle after a gnt counts as a new request. Requesters must deassert req in the cycle after gnt if no further read is wanted.
- hold_cnt saturates at MAX_HOLD and never wraps.
- lock/req changes during sAddr/sCap have no effect until sIdle.

## Timing
- Grant edge E0 (sIdle→sAddr, gnt pulse, rom_addr valid after E0).
- ROM samples at E1. rd_data/rd_valid asserted after E2. Latency req→rd_valid = 3 cycles when uncontended.
- Throughput: one read per 3 cycles; no overlap of accesses.
- Reset asserted mid-access: access is abandoned, no rd_valid is produced, and all outputs return to reset values immediately (asynchronously).

## Structure
- Shared package: state encoding (sIdle, sAddr, sCap), requester indices (REQ_LOGIN=0, REQ_SCORE=1), ROM end-of-memory marker 16'hFFFF (used by requesters, not interpreted here).
- One sub-module: rr_pick2, a combinational two-way round-robin pick from req, last, locked owner and hold-limit flag, returning a one-hot grant. The FSM, hold counter and datapath registers live in the top level.

## Test plan
- Reset, then req[1]=1 with addr1=8'h05 and ROM[5]=16'h1235: gnt=2'b10 at E0, rd_valid=2'b10 with rd_data=16'h1235 three cycles later.
- req=2'b11 from reset: requester 0 is granted first, then requester 1 on the next sIdle; alternation continues while both hold req.
- Requester 0 with lock=1 scanning addresses 0..40, MAX_HOLD=4, req[1] high from cycle 0: sequence is four grants to 0, one grant to 1, then four grants to 0, repeating.
- Locked owner 0 drops req in sIdle while req[1]=1: gnt[1] in that same cycle and hold_cnt=1.
- rst pulled low during sAddr: no rd_valid, rom_addr=0, busy=0 immediately. After release, a new req[0] completes normally.
- Scan to an address holding 16'hFFFF: rd_data=16'hFFFF delivered unaltered with rd_valid[0]; the arbiter returns to sIdle.
